spi_slave_rf: RTL and testbench
===============================

# spi_slave_rf

SPI responder (mode 0: CPOL=0, CPHA=0, MSB first, 8-bit) for the side board's serial link. It is the device end of the link driven by our SPI master. All SPI inputs are oversampled and synchronized into the single system clock domain. It returns received bytes with a one-cycle valid pulse and shifts out bytes from a one-entry transmit holding register, with an idle byte on underrun.

## Interface
Parameters:
- IDLE_BYTE, 8'hFF, byte shifted out when the holding register is empty at a byte boundary.

Ports:
- clk  in  1  system clock (100 MHz)
- rstn  in  1  asynchronous active-low reset
- sclk  in  1  SPI clock from master, asynchronous to clk
- csn  in  1  chip select from master, active low, asynchronous
- mosi  in  1  master data in, asynchronous
- miso  out  1  slave data out; 0 while deselected
- tx_byte  in  8  next byte to transmit
- tx_load  in  1  write tx_byte into holding register when tx_ready=1
- tx_ready  out  1  holding register empty
- tx_underrun  out  1  1-cycle pulse: IDLE_BYTE substituted at a load point
- rx_byte  out  8  last complete received byte
- rx_valid  out  1  1-cycle pulse: rx_byte updated
- busy  out  1  frame active (synchronized csn low)
- frame_end  out  1  1-cycle pulse on synchronized csn rising edge

## Operation
- sclk, csn and mosi each pass through a 2-FF synchronizer. The previous synchronized value is registered for edge detect: sclk_rise, sclk_fall, csn_fall, csn_rise.
- States:
  - IDLE (csn high): miso=0, busy=0.
  - SHIFT (csn low).
- IDLE→SHIFT on csn_fall:
  - bit_cnt=7.
  - Load point: sh_tx takes the holding register if it is full, otherwise IDLE_BYTE with a tx_underrun pulse.
  - miso=sh_tx bit 7 (next-state value).
- SHIFT, on sclk_rise:
  - sh_rx[bit_cnt]<=mosi_sync.
  - If bit_cnt=0: rx_byte<={sh_rx[7:1],mosi_sync}, rx_valid pulse, set reload flag, bit_cnt=7.
  - Otherwise bit_cnt-1.
- SHIFT, on sclk_fall:
  - If the reload flag is set: perform the load point, drive miso=new byte bit 7, clear the flag.
  - Otherwise miso=sh_tx[bit_cnt].
- SHIFT→IDLE on csn_rise:
  - frame_end pulse.
  - Partial byte discarded: no rx_valid, sh_rx cleared, bit_cnt=7, reload flag cleared.
  - A byte already moved into sh_tx is lost. The holding register is untouched.
- Multi-byte frames (csn held low): bytes are back-to-back, and each rising edge at bit_cnt=0 yields rx_valid.
- Holding register:
  - tx_load with tx_ready=1 stores tx_byte and clears tx_ready.
  - tx_load with tx_ready=0 is ignored; the stored byte is kept.
  - A load point consumes it and sets tx_ready.
  - tx_load in the same cycle as a consuming load point is accepted after consumption: the new byte is stored and tx_ready stays 0.
- Simultaneous csn_rise and sclk edge in one cycle: csn_rise wins and the sclk edge is ignored.
- sclk edges while in IDLE are ignored.

## Timing
- Reset values: miso=0, tx_ready=1, tx_underrun=0, rx_byte=8'h00, rx_valid=0, busy=0, frame_end=0, state=IDLE, synchronizer flops at idle levels (sclk 0, csn 1, mosi 0).
- Edge detection latency: 3 clk from the pin transition (2 synchronizer + 1 detect).
- rx_valid is asserted 4 clk after the 8th sclk pin rise.
- miso updates 4 clk after the sclk pin fall (or csn pin fall).
- Requirement: sclk high and low times ≥ 8 clk each, and csn setup to first sclk rise ≥ 8 clk. The master at DIV=50 gives 50 clk.
- Hold margin: miso changes ≥ 4 clk after the falling edge and is stable through the next rise.
- tx_byte is sampled only in the tx_load cycle.
- rstn asserted mid-frame: immediate return to reset values. After release, the block waits for a fresh csn_fall and does not resume mid-frame.

## Test plan
- Single byte: preload 8'hA5, csn low, master sends 8'h3C at 50-clk half-period → miso bits 1,0,1,0,0,1,0,1. rx_byte=8'h3C with one rx_valid pulse, tx_ready=1 after csn_fall, frame_end on csn high.
- Three-byte frame with csn held low: load 8'h11, then 8'h22 and 8'h33 via tx_ready handshakes; master sends 8'h01,8'h02,8'h03 → miso bytes 11,22,33 and three rx_valid pulses with 01,02,03.
- Underrun: no preload, master sends 8'h55 → miso 8'hFF, one tx_underrun pulse at csn_fall, rx_byte=8'h55.
- Abort: csn rises after 5 sclk rises → no rx_valid, rx_byte keeps its previous value, frame_end pulse. The next full frame receives 8'h9E correctly.
- Holding register: tx_load 8'h77 then tx_load 8'h88 while tx_ready=0 → 8'h77 transmitted. Also check tx_load coincident with the load point.
- Reset mid-frame at bit 3 → all outputs at reset values. After rstn release with csn still low, no rx_valid until a new csn_fall.

Source files
------------

// File: rtl/spi_slave_rf.sv
// rtl/spi_slave_rf.sv - SPI mode-0 responder with oversampled pins and one-entry transmit holding register
module spi_slave_rf #(
    parameter logic [7:0] IDLE_BYTE = 8'hFF
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       sclk,
    input  logic       csn,
    input  logic       mosi,
    output logic       miso,
    input  logic [7:0] tx_byte,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic       tx_underrun,
    output logic [7:0] rx_byte,
    output logic       rx_valid,
    output logic       busy,
    output logic       frame_end
);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state, state_n;

    logic sclk_s1, sclk_s2, sclk_prev;
    logic csn_s1, csn_s2, csn_prev;
    logic mosi_s1, mosi_s2;
    logic sclk_rise, sclk_fall, csn_fall, csn_rise;
    logic started, armed;

    logic [7:0] sh_tx;
    logic [7:0] sh_rx;
    logic [2:0] bit_cnt;
    logic       reload;
    logic [7:0] hold_data;
    logic       hold_full;

    logic       load_pt;
    logic       do_rx;
    logic       do_tx;
    logic       do_abort;
    logic [7:0] load_byte;

    // Pin synchronizers, registered edge pulses, and the csn arming flag.
    // armed only rises once csn has really been seen high after reset, so a
    // reset released while csn is already low cannot fake a csn fall.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sclk_s1   <= 1'b0;
            sclk_s2   <= 1'b0;
            sclk_prev <= 1'b0;
            csn_s1    <= 1'b1;
            csn_s2    <= 1'b1;
            csn_prev  <= 1'b1;
            mosi_s1   <= 1'b0;
            mosi_s2   <= 1'b0;
            sclk_rise <= 1'b0;
            sclk_fall <= 1'b0;
            csn_fall  <= 1'b0;
            csn_rise  <= 1'b0;
            started   <= 1'b0;
            armed     <= 1'b0;
        end else begin
            sclk_s1   <= sclk;
            sclk_s2   <= sclk_s1;
            sclk_prev <= sclk_s2;
            csn_s1    <= csn;
            csn_s2    <= csn_s1;
            csn_prev  <= csn_s2;
            mosi_s1   <= mosi;
            mosi_s2   <= mosi_s1;
            sclk_rise <= sclk_s2 & ~sclk_prev;
            sclk_fall <= ~sclk_s2 & sclk_prev;
            csn_fall  <= armed & csn_prev & ~csn_s2;
            csn_rise  <= csn_s2 & ~csn_prev;
            started   <= 1'b1;
            armed     <= armed | (started & csn_s1);
        end
    end

    // Frame state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next state and per-cycle actions; csn_rise takes priority over sclk edges.
    always_comb begin
        state_n  = state;
        load_pt  = 1'b0;
        do_rx    = 1'b0;
        do_tx    = 1'b0;
        do_abort = 1'b0;
        case (state)
            IDLE: begin
                if (csn_fall) begin
                    state_n = SHIFT;
                    load_pt = 1'b1;
                end
            end
            SHIFT: begin
                if (csn_rise) begin
                    state_n  = IDLE;
                    do_abort = 1'b1;
                end else if (sclk_rise) begin
                    do_rx = 1'b1;
                end else if (sclk_fall) begin
                    if (reload) begin
                        load_pt = 1'b1;
                    end else begin
                        do_tx = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign load_byte = hold_full ? hold_data : IDLE_BYTE;
    assign tx_ready  = ~hold_full;
    assign busy      = (state == SHIFT);

    // Shift registers, holding register and output pulses.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            sh_tx       <= 8'h00;
            sh_rx       <= 8'h00;
            bit_cnt     <= 3'd7;
            reload      <= 1'b0;
            miso        <= 1'b0;
            hold_data   <= 8'h00;
            hold_full   <= 1'b0;
            rx_byte     <= 8'h00;
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_end   <= 1'b0;
        end else begin
            rx_valid    <= 1'b0;
            tx_underrun <= 1'b0;
            frame_end   <= 1'b0;

            // A consuming load point frees the slot before a same-cycle tx_load lands.
            if (tx_load && (!hold_full || load_pt)) begin
                hold_data <= tx_byte;
                hold_full <= 1'b1;
            end else if (load_pt) begin
                hold_full <= 1'b0;
            end

            if (load_pt) begin
                sh_tx       <= load_byte;
                miso        <= load_byte[7];
                tx_underrun <= ~hold_full;
                reload      <= 1'b0;
                if (state == IDLE) begin
                    bit_cnt <= 3'd7;
                end
            end

            if (do_rx) begin
                sh_rx[bit_cnt] <= mosi_s2;
                if (bit_cnt == 3'd0) begin
                    rx_byte  <= {sh_rx[7:1], mosi_s2};
                    rx_valid <= 1'b1;
                    reload   <= 1'b1;
                    bit_cnt  <= 3'd7;
                end else begin
                    bit_cnt <= bit_cnt - 3'd1;
                end
            end

            if (do_tx) begin
                miso <= sh_tx[bit_cnt];
            end

            if (do_abort) begin
                frame_end <= 1'b1;
                sh_rx     <= 8'h00;
                bit_cnt   <= 3'd7;
                reload    <= 1'b0;
                miso      <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_rf.sv
// tb/tb_spi_slave_rf.sv - scoreboard testbench for spi_slave_rf
module tb_spi_slave_rf;

    localparam int HALF = 50;

    logic       clk;
    logic       rstn;
    logic       sclk;
    logic       csn;
    logic       mosi;
    logic       miso;
    logic [7:0] tx_byte;
    logic       tx_load;
    logic       tx_ready;
    logic       tx_underrun;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       busy;
    logic       frame_end;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rxv  = 0;
    int n_und  = 0;
    int n_fe   = 0;

    logic [7:0] rxq[$];
    logic [7:0] mq[$];

    spi_slave_rf #(.IDLE_BYTE(8'hFF)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .sclk        (sclk),
        .csn         (csn),
        .mosi        (mosi),
        .miso        (miso),
        .tx_byte     (tx_byte),
        .tx_load     (tx_load),
        .tx_ready    (tx_ready),
        .tx_underrun (tx_underrun),
        .rx_byte     (rx_byte),
        .rx_valid    (rx_valid),
        .busy        (busy),
        .frame_end   (frame_end)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receive-side scoreboard and pulse counters.
    always @(negedge clk) begin
        if (rstn) begin
            if (rx_valid) begin
                n_rxv++;
                if (rxq.size() == 0) begin
                    check("rx_unexpected", 8'd1, 8'd0);
                end else begin
                    check("rx_byte", rx_byte, rxq.pop_front());
                end
            end
            if (tx_underrun) n_und++;
            if (frame_end) n_fe++;
        end
    end

    initial begin
        repeat (60000) @(posedge clk);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic load_tx(input logic [7:0] b);
        @(negedge clk);
        tx_byte = b;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
    endtask

    task automatic wait_ready();
        int k = 0;
        while (!tx_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!tx_ready) check("tx_ready_timeout", 8'd0, 8'd1);
    endtask

    task automatic frame_begin();
        @(negedge clk);
        csn  = 1'b0;
        sclk = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    // One byte from the master; the final fall of a frame coincides with csn rising.
    task automatic xbyte(input logic [7:0] d, input int nbits, input bit last,
                         input logic [7:0] em, input bit chk);
        logic [7:0] got;
        got = 8'h00;
        if (chk) begin
            rxq.push_back(d);
            mq.push_back(em);
        end
        for (int i = 7; i > 7 - nbits; i--) begin
            mosi = d[i];
            repeat (HALF) @(negedge clk);
            got[i] = miso;
            sclk = 1'b1;
            repeat (HALF) @(negedge clk);
            sclk = 1'b0;
            if (last && i == 8 - nbits) csn = 1'b1;
        end
        if (chk) check("miso_byte", got, mq.pop_front());
    endtask

    task automatic frame_done();
        repeat (HALF) @(negedge clk);
        check("rx_missing", 8'(rxq.size()), 8'd0);
        check("busy_idle", 8'(busy), 8'd0);
        check("miso_idle", 8'(miso), 8'd0);
    endtask

    int s_rxv, s_und, s_fe;

    initial begin
        rstn = 1'b0; sclk = 1'b0; csn = 1'b1; mosi = 1'b0;
        tx_byte = 8'h00; tx_load = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_miso", 8'(miso), 8'd0);
        check("rst_tx_ready", 8'(tx_ready), 8'd1);
        check("rst_rx_byte", rx_byte, 8'h00);
        check("rst_busy", 8'(busy), 8'd0);
        check("rst_pulses", {5'd0, rx_valid, tx_underrun, frame_end}, 8'd0);
        rstn = 1'b1;
        repeat (10) @(negedge clk);

        // Single byte with preload.
        load_tx(8'hA5);
        check("preload_ready", 8'(tx_ready), 8'd0);
        s_und = n_und; s_fe = n_fe;
        frame_begin();
        check("ready_after_fall", 8'(tx_ready), 8'd1);
        check("busy_frame", 8'(busy), 8'd1);
        xbyte(8'h3C, 8, 1'b1, 8'hA5, 1'b1);
        frame_done();
        check("single_fe", 8'(n_fe - s_fe), 8'd1);
        check("single_no_underrun", 8'(n_und - s_und), 8'd0);

        // Three-byte frame with tx_ready handshakes.
        load_tx(8'h11);
        s_rxv = n_rxv;
        fork
            begin
                frame_begin();
                xbyte(8'h01, 8, 1'b0, 8'h11, 1'b1);
                xbyte(8'h02, 8, 1'b0, 8'h22, 1'b1);
                xbyte(8'h03, 8, 1'b1, 8'h33, 1'b1);
            end
            begin
                repeat (5) @(negedge clk);
                wait_ready();
                load_tx(8'h22);
                wait_ready();
                load_tx(8'h33);
            end
        join
        frame_done();
        check("multi_rxv", 8'(n_rxv - s_rxv), 8'd3);

        // Underrun.
        s_und = n_und;
        frame_begin();
        xbyte(8'h55, 8, 1'b1, 8'hFF, 1'b1);
        frame_done();
        check("underrun_cnt", 8'(n_und - s_und), 8'd1);

        // Abort after five rises, then a full frame.
        s_rxv = n_rxv; s_fe = n_fe;
        frame_begin();
        xbyte(8'hB7, 5, 1'b1, 8'h00, 1'b0);
        frame_done();
        check("abort_no_rxv", 8'(n_rxv - s_rxv), 8'd0);
        check("abort_rx_keep", rx_byte, 8'h55);
        check("abort_fe", 8'(n_fe - s_fe), 8'd1);
        frame_begin();
        xbyte(8'h9E, 8, 1'b1, 8'hFF, 1'b1);
        frame_done();

        // Holding register: second load while full is ignored.
        load_tx(8'h77);
        load_tx(8'h88);
        check("hold_full_ready", 8'(tx_ready), 8'd0);
        frame_begin();
        xbyte(8'h5A, 8, 1'b1, 8'h77, 1'b1);
        frame_done();
        check("hold_drop_ready", 8'(tx_ready), 8'd1);

        // tx_load coincident with the csn_fall load point (4 clk after the pin).
        load_tx(8'hAA);
        s_und = n_und;
        @(negedge clk);
        csn = 1'b0;
        repeat (3) @(negedge clk);
        tx_byte = 8'hBB;
        tx_load = 1'b1;
        @(negedge clk);
        tx_load = 1'b0;
        check("coinc_ready", 8'(tx_ready), 8'd0);
        repeat (HALF) @(negedge clk);
        xbyte(8'hC5, 8, 1'b1, 8'hAA, 1'b1);
        frame_done();
        check("coinc_no_underrun", 8'(n_und - s_und), 8'd0);
        frame_begin();
        xbyte(8'h3A, 8, 1'b1, 8'hBB, 1'b1);
        frame_done();

        // Reset mid-frame at bit 3; csn stays low across release.
        load_tx(8'h42);
        frame_begin();
        xbyte(8'hE1, 3, 1'b0, 8'h00, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        check("mrst_miso", 8'(miso), 8'd0);
        check("mrst_tx_ready", 8'(tx_ready), 8'd1);
        check("mrst_rx_byte", rx_byte, 8'h00);
        check("mrst_busy", 8'(busy), 8'd0);
        check("mrst_pulses", {5'd0, rx_valid, tx_underrun, frame_end}, 8'd0);
        repeat (5) @(negedge clk);
        rstn = 1'b1;
        s_rxv = n_rxv;
        xbyte(8'h66, 8, 1'b0, 8'h00, 1'b0);
        repeat (20) @(negedge clk);
        check("mrst_no_rxv", 8'(n_rxv - s_rxv), 8'd0);
        check("mrst_stay_idle", 8'(busy), 8'd0);
        csn = 1'b1;
        repeat (HALF) @(negedge clk);
        frame_begin();
        xbyte(8'hC3, 8, 1'b1, 8'hFF, 1'b1);
        frame_done();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
